// File: rtl/uart_pkg.sv
// Shared constants and state encoding for the memory-mapped 8N1 UART.
package uart_pkg;

  localparam logic [31:0] UART_TXD_ADDR = 32'h4000_0018;
  localparam logic [31:0] UART_RXD_ADDR = 32'h4000_001C;
  localparam logic [31:0] UART_CON_ADDR = 32'h4000_0020;

  localparam int CON_TX_IRQ_EN  = 0;
  localparam int CON_RX_IRQ_EN  = 1;
  localparam int CON_TX_DONE    = 2;
  localparam int CON_RX_VALID   = 3;
  localparam int CON_TX_BUSY    = 4;
  localparam int CON_RX_OVERRUN = 5;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } uart_state_e;

endpackage

// File: rtl/uart_rx_core.sv
// Receive path: 2-FF synchronizer, mid-bit sampling FSM and shift register.
// state    | meaning
// ST_IDLE  | waiting for a synchronized falling edge
// ST_START | half-bit wait, then confirm start bit is still low
// ST_DATA  | sample 8 data bits, LSB first, one per bit period
// ST_STOP  | sample stop bit; publish byte only if it is high
module uart_rx_core
  import uart_pkg::*;
#(
  parameter int BAUD_DIV = 5208
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       uart_rx,
  output logic [7:0] rx_byte,
  output logic       rx_done
);

  localparam int CNT_W = $clog2(BAUD_DIV);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(BAUD_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(BAUD_DIV / 2 - 1);

  logic             sync1_q, sync2_q, prev_q;
  uart_state_e      state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [2:0]       bit_q;
  logic [7:0]       shift_q;
  logic [7:0]       rx_byte_q;
  logic             rx_done_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      sync1_q   <= 1'b1;
      sync2_q   <= 1'b1;
      prev_q    <= 1'b1;
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      bit_q     <= '0;
      shift_q   <= '0;
      rx_byte_q <= '0;
      rx_done_q <= 1'b0;
    end else begin
      sync1_q   <= uart_rx;
      sync2_q   <= sync1_q;
      prev_q    <= sync2_q;
      rx_done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (prev_q && !sync2_q) begin
            state_q <= ST_START;
            cnt_q   <= CNT_HALF;
          end
        end
        ST_START: begin
          if (cnt_q == '0) begin
            // A line that is high again at mid-start was a glitch
            state_q <= sync2_q ? ST_IDLE : ST_DATA;
            cnt_q   <= CNT_FULL;
            bit_q   <= '0;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        ST_DATA: begin
          if (cnt_q == '0) begin
            shift_q <= {sync2_q, shift_q[7:1]};
            cnt_q   <= CNT_FULL;
            if (bit_q == 3'd7) state_q <= ST_STOP;
            else bit_q <= bit_q + 1'b1;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        ST_STOP: begin
          if (cnt_q == '0) begin
            if (sync2_q) begin
              rx_byte_q <= shift_q;
              rx_done_q <= 1'b1;
            end
            state_q <= ST_IDLE;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign rx_byte = rx_byte_q;
  assign rx_done = rx_done_q;

endmodule

// File: rtl/uart_peripheral.sv
// Bus-mapped UART: TXD/RXD/CON registers, transmit FSM and interrupt request.
// state    | meaning
// ST_IDLE  | line high, waiting for a TXD write
// ST_START | driving start bit (low)
// ST_DATA  | driving 8 data bits, LSB first
// ST_STOP  | driving stop bit (high); TX_DONE on completion
module uart_peripheral
  import uart_pkg::*;
#(
  parameter int BAUD_DIV = 5208
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rd,
  input  logic        wr,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  input  logic        uart_rx,
  output logic        uart_tx,
  output logic        irqout
);

  localparam int CNT_W = $clog2(BAUD_DIV);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(BAUD_DIV - 1);

  uart_state_e      tx_state_q;
  logic [CNT_W-1:0] tx_cnt_q;
  logic [2:0]       tx_bit_q;
  logic [7:0]       tx_shift_q, txd_q, rxd_q;
  logic             uart_tx_q, tx_done_q;
  logic [1:0]       con_q;
  logic             rx_valid_q, rx_valid_d, rx_ovr_q, rx_ovr_d;
  logic [7:0]       rx_byte;
  logic             rx_done, tx_busy;
  logic             txd_wr, con_wr, rxd_rd, con_rd;
  logic             unused_wdata;

  assign unused_wdata = ^wdata[31:8];
  assign tx_busy = (tx_state_q != ST_IDLE);
  assign txd_wr  = wr && (addr == UART_TXD_ADDR) && !tx_busy;
  assign con_wr  = wr && (addr == UART_CON_ADDR);
  assign rxd_rd  = rd && (addr == UART_RXD_ADDR);
  assign con_rd  = rd && (addr == UART_CON_ADDR);

  uart_rx_core #(.BAUD_DIV(BAUD_DIV)) u_rx (
    .clk     (clk),
    .reset   (reset),
    .uart_rx (uart_rx),
    .rx_byte (rx_byte),
    .rx_done (rx_done)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      tx_state_q <= ST_IDLE;
      tx_cnt_q   <= '0;
      tx_bit_q   <= '0;
      tx_shift_q <= '0;
      txd_q      <= '0;
      uart_tx_q  <= 1'b1;
      tx_done_q  <= 1'b0;
    end else begin
      if (con_rd) tx_done_q <= 1'b0;
      case (tx_state_q)
        ST_IDLE: begin
          if (txd_wr) begin
            txd_q      <= wdata[7:0];
            tx_shift_q <= wdata[7:0];
            tx_state_q <= ST_START;
            tx_cnt_q   <= CNT_FULL;
            uart_tx_q  <= 1'b0;
            tx_done_q  <= 1'b0;
          end
        end
        ST_START: begin
          if (tx_cnt_q == '0) begin
            tx_state_q <= ST_DATA;
            tx_cnt_q   <= CNT_FULL;
            tx_bit_q   <= '0;
            uart_tx_q  <= tx_shift_q[0];
          end else begin
            tx_cnt_q <= tx_cnt_q - 1'b1;
          end
        end
        ST_DATA: begin
          if (tx_cnt_q == '0) begin
            tx_cnt_q <= CNT_FULL;
            if (tx_bit_q == 3'd7) begin
              tx_state_q <= ST_STOP;
              uart_tx_q  <= 1'b1;
            end else begin
              tx_bit_q   <= tx_bit_q + 1'b1;
              tx_shift_q <= tx_shift_q >> 1;
              uart_tx_q  <= tx_shift_q[1];
            end
          end else begin
            tx_cnt_q <= tx_cnt_q - 1'b1;
          end
        end
        ST_STOP: begin
          if (tx_cnt_q == '0) begin
            tx_state_q <= ST_IDLE;
            tx_done_q  <= 1'b1;
          end else begin
            tx_cnt_q <= tx_cnt_q - 1'b1;
          end
        end
        default: tx_state_q <= ST_IDLE;
      endcase
    end
  end

  // A byte landing on the same edge as an RXD read survives and is not an overrun
  always_comb begin
    rx_valid_d = rx_valid_q;
    rx_ovr_d   = rx_ovr_q;
    if (rxd_rd) begin
      rx_valid_d = 1'b0;
      rx_ovr_d   = 1'b0;
    end
    if (rx_done) begin
      rx_valid_d = 1'b1;
      if (rx_valid_q && !rxd_rd) rx_ovr_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      con_q      <= '0;
      rxd_q      <= '0;
      rx_valid_q <= 1'b0;
      rx_ovr_q   <= 1'b0;
    end else begin
      if (con_wr) con_q <= wdata[1:0];
      if (rx_done) rxd_q <= rx_byte;
      rx_valid_q <= rx_valid_d;
      rx_ovr_q   <= rx_ovr_d;
    end
  end

  always_comb begin
    rdata = '0;
    if (rd) begin
      case (addr)
        UART_TXD_ADDR: rdata = {24'b0, txd_q};
        UART_RXD_ADDR: rdata = {24'b0, rxd_q};
        UART_CON_ADDR: rdata = {26'b0, rx_ovr_q, tx_busy, rx_valid_q, tx_done_q, con_q};
        default:       rdata = '0;
      endcase
    end
  end

  assign uart_tx = uart_tx_q;
  assign irqout  = (tx_done_q & con_q[CON_TX_IRQ_EN]) | (rx_valid_q & con_q[CON_RX_IRQ_EN]);

endmodule

// File: tb/tb_uart_peripheral.sv
// Self-checking bench for uart_peripheral: register-level model, frame timing, RX flags, reset.
module tb_uart_peripheral;
  import uart_pkg::*;

  localparam int BD = 16;

  logic        clk = 1'b0, reset = 1'b0, rd = 1'b0, wr = 1'b0, uart_rx = 1'b1;
  logic [31:0] addr = '0, wdata = '0;
  logic [31:0] rdata;
  logic        uart_tx, irqout;

  int checks = 0, errors = 0;

  // Register-level model of the peripheral as seen from the bus
  logic [7:0] m_txd = 0, m_rxd = 0;
  logic [1:0] m_con = 0;
  logic       m_done = 0, m_valid = 0, m_ovr = 0;

  uart_peripheral #(.BAUD_DIV(BD)) dut (
    .clk(clk), .reset(reset), .rd(rd), .wr(wr), .addr(addr), .wdata(wdata),
    .rdata(rdata), .uart_rx(uart_rx), .uart_tx(uart_tx), .irqout(irqout)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] addr; logic [31:0] exp; } rd_vec_t;
  typedef struct { logic [7:0] data; logic [1:0] con; } tx_vec_t;
  typedef struct { logic [7:0] data; logic stop; logic read_after; } rx_vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] exp_con();
    return {26'b0, m_ovr, 1'b0, m_valid, m_done, m_con};
  endfunction

  function automatic logic exp_irq();
    return (m_done & m_con[0]) | (m_valid & m_con[1]);
  endfunction

  task automatic model_reset();
    m_txd = 0; m_rxd = 0; m_con = 0; m_done = 0; m_valid = 0; m_ovr = 0;
  endtask

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk); addr = a; wdata = d; wr = 1'b1;
    @(negedge clk); wr = 1'b0; addr = '0; wdata = '0;
  endtask

  task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
    @(negedge clk); addr = a; rd = 1'b1;
    #1 d = rdata;
    @(negedge clk); rd = 1'b0; addr = '0;
  endtask

  task automatic mdl_write(input logic [31:0] a, input logic [31:0] d);
    bus_write(a, d);
    if (a == UART_CON_ADDR) m_con = d[1:0];
    if (a == UART_TXD_ADDR) begin m_txd = d[7:0]; m_done = 1'b0; end
  endtask

  task automatic read_chk(input logic [31:0] a, input string name);
    logic [31:0] d, e;
    case (a)
      UART_TXD_ADDR: e = {24'b0, m_txd};
      UART_RXD_ADDR: e = {24'b0, m_rxd};
      UART_CON_ADDR: e = exp_con();
      default:       e = '0;
    endcase
    bus_read(a, d);
    chk(name, d, e);
    if (a == UART_RXD_ADDR) begin m_valid = 1'b0; m_ovr = 1'b0; end
    if (a == UART_CON_ADDR) m_done = 1'b0;
  endtask

  // Called right after the accepting write; checks each bit mid-period and the done boundary
  task automatic tx_frame_check(input logic [7:0] data, input string tag);
    logic [9:0] frame;
    frame = {1'b1, data, 1'b0};
    chk($sformatf("%s start edge", tag), uart_tx, 1'b0);
    repeat (BD/2) @(negedge clk);
    for (int b = 0; b < 10; b++) begin
      chk($sformatf("%s bit%0d", tag, b), uart_tx, frame[b]);
      if (b < 9) repeat (BD) @(negedge clk);
    end
    repeat (BD/2 - 1) @(negedge clk);
    chk($sformatf("%s irq before done", tag), irqout, exp_irq());
    @(negedge clk);
    m_done = 1'b1;
    chk($sformatf("%s irq at done", tag), irqout, exp_irq());
  endtask

  task automatic send_rx(input logic [7:0] data, input logic stop);
    logic [9:0] frame;
    frame = {stop, data, 1'b0};
    for (int b = 0; b < 10; b++) begin
      @(negedge clk); uart_rx = frame[b];
      repeat (BD - 1) @(negedge clk);
    end
    uart_rx = 1'b1;
    repeat (BD) @(negedge clk);
    if (stop) begin
      if (m_valid) m_ovr = 1'b1;
      m_rxd = data;
      m_valid = 1'b1;
    end
  endtask

  rd_vec_t rv[4];
  tx_vec_t tv[6];
  rx_vec_t xv[8];

  initial begin
    logic [31:0] d;
    rv[0] = '{UART_TXD_ADDR, 32'h0};
    rv[1] = '{UART_RXD_ADDR, 32'h0};
    rv[2] = '{UART_CON_ADDR, 32'h0};
    rv[3] = '{32'h4000_0010, 32'h0};
    tv[0] = '{8'hA5, 2'b01};
    tv[1] = '{8'h00, 2'b01};
    tv[2] = '{8'hFF, 2'b00};
    for (int i = 3; i < 6; i++) tv[i] = '{8'($urandom), 2'($urandom_range(0, 1))};
    xv[0] = '{8'h5A, 1'b1, 1'b1};
    xv[1] = '{8'h11, 1'b1, 1'b0};
    xv[2] = '{8'h22, 1'b1, 1'b1};
    xv[3] = '{8'h77, 1'b0, 1'b0};
    for (int i = 4; i < 8; i++) xv[i] = '{8'($urandom), 1'b1, 1'($urandom_range(0, 1))};

    // Reset and idle reads
    repeat (2) @(negedge clk);
    reset = 1'b1;
    model_reset();
    @(negedge clk);
    chk("reset uart_tx", uart_tx, 1'b1);
    chk("reset irqout", irqout, 1'b0);
    for (int i = 0; i < 4; i++) begin
      bus_read(rv[i].addr, d);
      chk($sformatf("reset read %08h", rv[i].addr), d, rv[i].exp);
    end

    // Transmit table: exact bit timing, done boundary, CON/TXD readback
    for (int i = 0; i < 6; i++) begin
      mdl_write(UART_CON_ADDR, {30'b0, tv[i].con});
      mdl_write(UART_TXD_ADDR, {24'b0, tv[i].data});
      tx_frame_check(tv[i].data, $sformatf("tx%0d", i));
      read_chk(UART_CON_ADDR, $sformatf("tx%0d con", i));
      chk($sformatf("tx%0d irq after con read", i), irqout, exp_irq());
      read_chk(UART_TXD_ADDR, $sformatf("tx%0d txd", i));
    end

    // Write while busy is ignored
    mdl_write(UART_TXD_ADDR, 32'h3C);
    fork
      tx_frame_check(8'h3C, "busy-write");
      begin repeat (3) @(negedge clk); bus_write(UART_TXD_ADDR, 32'hFF); end
    join
    read_chk(UART_TXD_ADDR, "busy-write txd");
    read_chk(UART_CON_ADDR, "busy-write con");

    // Receive table: valid, overrun, framing error, random bytes
    mdl_write(UART_CON_ADDR, 32'h2);
    for (int i = 0; i < 8; i++) begin
      send_rx(xv[i].data, xv[i].stop);
      chk($sformatf("rx%0d irq", i), irqout, exp_irq());
      read_chk(UART_CON_ADDR, $sformatf("rx%0d con", i));
      if (xv[i].read_after) read_chk(UART_RXD_ADDR, $sformatf("rx%0d rxd", i));
    end
    read_chk(32'h4000_0024, "out-of-window read");

    // Short low glitch must not produce a byte
    if (m_valid) read_chk(UART_RXD_ADDR, "pre-glitch rxd");
    @(negedge clk); uart_rx = 1'b0;
    repeat (4) @(negedge clk); uart_rx = 1'b1;
    repeat (3*BD) @(negedge clk);
    read_chk(UART_CON_ADDR, "glitch con");
    chk("glitch irq", irqout, exp_irq());

    // Reset in the middle of data bit 3
    mdl_write(UART_TXD_ADDR, 32'h96);
    repeat (4*BD + BD/2) @(negedge clk);
    chk("mid-tx bit3", uart_tx, 1'b0);
    reset = 1'b0;
    @(negedge clk);
    chk("mid-tx reset line", uart_tx, 1'b1);
    chk("mid-tx reset irq", irqout, 1'b0);
    reset = 1'b1;
    model_reset();
    read_chk(UART_CON_ADDR, "post-reset con");
    read_chk(UART_TXD_ADDR, "post-reset txd");
    mdl_write(UART_TXD_ADDR, 32'h69);
    tx_frame_check(8'h69, "post-reset");
    read_chk(UART_TXD_ADDR, "post-reset txd2");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
